// File: rtl/step_gen_bus.sv
// Multi-channel step/dir pulse generator, slave on the picorv32 native memory bus.
// Channel n owns PERIOD/STEPS/CTRL/STATUS at BASE_ADDR + 16*n; read data is zero when not acknowledging.
module step_gen_bus #(
    parameter int          CHANNELS    = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0100,
    parameter int          CNT_WIDTH   = 32,
    parameter int          PULSE_WIDTH = 25,
    parameter int          DIR_SETUP   = 25
) (
    input  logic                clk_in,
    input  logic                reset_n_in,
    input  logic                mem_valid,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic                mem_ready,
    output logic [31:0]         mem_rdata,
    output logic [CHANNELS-1:0] step_out,
    output logic [CHANNELS-1:0] dir_out,
    output logic [CHANNELS-1:0] busy_out,
    output logic                irq_out
);
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    localparam logic [31:0]          SPAN       = 32'(16 * CHANNELS);
    localparam logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(PULSE_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
    localparam logic [31:0]          PULSE_M1   = 32'(PULSE_WIDTH - 1);
    localparam logic [31:0]          SETUP_M1   = 32'(DIR_SETUP - 1);

    logic        acked_q, acked_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] offset, rd_val;
    logic        sel, accept, write_hit;
    logic [3:0]  ch_idx;
    logic [1:0]  reg_idx;

    state_t               state_q  [CHANNELS];
    state_t               state_d  [CHANNELS];
    logic [CNT_WIDTH-1:0] period_q [CHANNELS];
    logic [CNT_WIDTH-1:0] period_d [CHANNELS];
    logic [CNT_WIDTH-1:0] steps_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] steps_d  [CHANNELS];
    logic [CNT_WIDTH-1:0] pcnt_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] pcnt_d   [CHANNELS];
    logic [31:0]          tmr_q    [CHANNELS];
    logic [31:0]          tmr_d    [CHANNELS];
    logic [CHANNELS-1:0]  step_q, step_d;
    logic [CHANNELS-1:0]  dir_q, dir_d;
    logic [CHANNELS-1:0]  done_q, done_d;
    logic [CHANNELS-1:0]  aborted_q, aborted_d;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] eff_period(input logic [CNT_WIDTH-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both bounds.
    assign offset    = mem_addr - BASE_ADDR;
    assign sel       = mem_valid && (offset < SPAN);
    assign accept    = sel && !acked_q;
    assign write_hit = accept && (mem_wstrb != 4'b0000);
    assign ch_idx    = offset[7:4];
    assign reg_idx   = offset[3:2];

    always_comb begin
        rd_val = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (ch_idx == 4'(n)) begin
                case (reg_idx)
                    2'd0:    rd_val = 32'(period_q[n]);
                    2'd1:    rd_val = 32'(steps_q[n]);
                    2'd2:    rd_val = {30'b0, dir_q[n], 1'b0};
                    default: rd_val = {29'b0, aborted_q[n], done_q[n], state_q[n] != IDLE};
                endcase
            end
        end
        ready_d = accept;
        acked_d = mem_valid && (acked_q || accept);
        rdata_d = accept ? rd_val : 32'b0;
    end

    always_comb begin
        step_d    = step_q;
        dir_d     = dir_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        for (int n = 0; n < CHANNELS; n++) begin
            state_d[n]  = state_q[n];
            period_d[n] = period_q[n];
            steps_d[n]  = steps_q[n];
            pcnt_d[n]   = (pcnt_q[n] != '0) ? pcnt_q[n] - ONE : pcnt_q[n];
            tmr_d[n]    = tmr_q[n];

            if (write_hit && ch_idx == 4'(n) && reg_idx == 2'd0)
                period_d[n] = CNT_WIDTH'(merge_bytes(32'(period_q[n]), mem_wdata, mem_wstrb));
            if (write_hit && ch_idx == 4'(n) && reg_idx == 2'd1 && state_q[n] == IDLE)
                steps_d[n] = CNT_WIDTH'(merge_bytes(32'(steps_q[n]), mem_wdata, mem_wstrb));

            case (state_q[n])
                SETUP: begin
                    if (tmr_q[n] == 32'd0) begin
                        step_d[n]  = 1'b1;
                        state_d[n] = HIGH;
                        tmr_d[n]   = PULSE_M1;
                        pcnt_d[n]  = eff_period(period_q[n]) - ONE;
                    end else begin
                        tmr_d[n] = tmr_q[n] - 32'd1;
                    end
                end
                HIGH: begin
                    if (tmr_q[n] == 32'd0) begin
                        step_d[n]  = 1'b0;
                        steps_d[n] = steps_q[n] - ONE;
                        if (steps_q[n] == ONE) begin
                            state_d[n] = IDLE;
                            done_d[n]  = 1'b1;
                        end else begin
                            state_d[n] = LOW;
                        end
                    end else begin
                        tmr_d[n] = tmr_q[n] - 32'd1;
                    end
                end
                LOW: begin
                    if (pcnt_q[n] == '0) begin
                        step_d[n]  = 1'b1;
                        state_d[n] = HIGH;
                        tmr_d[n]   = PULSE_M1;
                        pcnt_d[n]  = eff_period(period_q[n]) - ONE;
                    end
                end
                default: ;
            endcase

            // ABORT takes priority over START and over whatever the channel was doing.
            if (write_hit && ch_idx == 4'(n) && reg_idx == 2'd2 && mem_wstrb[0]) begin
                if (mem_wdata[2]) begin
                    step_d[n]    = 1'b0;
                    state_d[n]   = IDLE;
                    aborted_d[n] = 1'b1;
                    done_d[n]    = 1'b0;
                end else if (mem_wdata[0] && state_q[n] == IDLE) begin
                    aborted_d[n] = 1'b0;
                    if (steps_q[n] != '0) begin
                        dir_d[n]   = mem_wdata[1];
                        done_d[n]  = 1'b0;
                        state_d[n] = SETUP;
                        tmr_d[n]   = SETUP_M1;
                    end else begin
                        done_d[n] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            acked_q   <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            step_q    <= '0;
            dir_q     <= '0;
            done_q    <= '0;
            aborted_q <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                state_q[n]  <= IDLE;
                period_q[n] <= '0;
                steps_q[n]  <= '0;
                pcnt_q[n]   <= '0;
                tmr_q[n]    <= '0;
            end
        end else begin
            acked_q   <= acked_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            for (int n = 0; n < CHANNELS; n++) begin
                state_q[n]  <= state_d[n];
                period_q[n] <= period_d[n];
                steps_q[n]  <= steps_d[n];
                pcnt_q[n]   <= pcnt_d[n];
                tmr_q[n]    <= tmr_d[n];
            end
        end
    end

    always_comb begin
        busy_out = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            busy_out[n] = (state_q[n] != IDLE);
        end
    end

    assign step_out  = step_q;
    assign dir_out   = dir_q;
    assign irq_out   = |done_q;
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
endmodule

// File: doc/step_gen_bus.md
Name: step_gen_bus

Overview:
- Memory-mapped, multi-channel step/dir pulse generator, a slave on the picorv32 native memory bus.
- Replaces the constant-zero step/dir pins with CPU-programmable motion channels.
- Each channel emits a programmed number of step pulses at a programmed period and direction, then reports done.
- Sits beside the other IO registers in the top level; read data is zero when not selected so it can be OR-combined onto the shared read bus.

Parameters:
CHANNELS, 12, number of independent step/dir channels (1..16)
BASE_ADDR, 32'h10000100, byte address of channel 0 register block
CNT_WIDTH, 32, width of PERIOD and STEPS counters
PULSE_WIDTH, 25, step_out high time in clk_in cycles (>=1)
DIR_SETUP, 25, cycles from dir_out update to first step rising edge (>=1)

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  asynchronous active-low reset
mem_valid  input  1  CPU bus request valid
mem_addr  input  32  byte address
mem_wdata  input  32  write data
mem_wstrb  input  4  byte write strobes; 0 = read
mem_ready  output  1  one-cycle acknowledge
mem_rdata  output  32  read data; 0 unless mem_ready is high for this block
step_out  output  CHANNELS  step pulses
dir_out  output  CHANNELS  direction lines
busy_out  output  CHANNELS  channel running
irq_out  output  1  OR of all DONE flags

Behaviour:
- Reset (async, reset_n_in=0): all outputs 0, all registers 0, every FSM in IDLE.
- Register map: channel n at BASE_ADDR + 16*n.
  - +0x0 PERIOD (RW): cycles between step rising edges.
  - +0x4 STEPS (RW): remaining steps.
  - +0x8 CTRL (W): bit0 START, bit1 DIR, bit2 ABORT. Reads return {30'b0, last DIR, 0}.
  - +0xC STATUS (RO): bit0 BUSY, bit1 DONE, bit2 ABORTED.
- Selection: mem_valid and BASE_ADDR <= mem_addr < BASE_ADDR + 16*CHANNELS. Unselected addresses are never acknowledged.
- Handshake:
  - mem_ready rises the cycle after a selected mem_valid and stays high exactly 1 cycle.
  - No re-acknowledge while mem_valid is held across the ready cycle.
  - Writes commit on the ready edge, honouring mem_wstrb per byte.
  - Read data is registered with mem_ready.
- Channel FSM: IDLE -> SETUP -> HIGH -> LOW -> HIGH ... -> IDLE.
- Start: CTRL write with START=1 commits at edge E.
  - If IDLE and STEPS != 0: dir_out=DIR, busy=1, DONE=0, ABORTED=0, state=SETUP at E.
  - If IDLE and STEPS == 0: DONE=1 at E, no pulse, stays IDLE.
  - If busy: START and DIR are ignored.
- SETUP: step_out rises at E+DIR_SETUP; enter HIGH.
- HIGH: step_out high for PULSE_WIDTH cycles, then LOW.
- LOW: the next rising edge occurs eff_period cycles after the previous one.
  - eff_period = max(PERIOD, PULSE_WIDTH+1).
  - PERIOD is sampled at each rising edge, so writes during a run apply from the next step.
- STEPS: decrements on each step_out falling edge.
  - When it reaches 0 at that edge: state=IDLE, busy=0, DONE=1, with no trailing period.
  - STEPS writes while busy are ignored.
  - STEPS reads return the live remaining count.
- ABORT=1 (any state): next edge step_out=0, state=IDLE, busy=0, ABORTED=1, DONE=0. STEPS keeps the remaining count.
- START and ABORT both set in one write: ABORT wins.
- DONE and ABORTED clear on the next accepted START. irq_out = OR of all DONE bits.
- dir_out holds its value in IDLE.
- Reset mid-pulse: step_out drops immediately (async).
- Counters are CNT_WIDTH unsigned with no wrap: PERIOD=0 is treated as PULSE_WIDTH+1.

Test Plan:
Bench uses CHANNELS=2, PULSE_WIDTH=3, DIR_SETUP=2, BASE_ADDR=0x10000100.
- Register access: write PERIOD ch0=10, read back -> mem_ready exactly 1 cycle after valid, rdata=10. Read address 0x10000120 -> no mem_ready, rdata=0.
- Basic run: ch0 STEPS=3, PERIOD=10, CTRL=0x3.
  - Required: dir_out[0]=1 at commit edge, first step_out rise 2 cycles later, 3 pulses each 3 high, rises 10 apart.
  - busy clears on the 3rd fall, then DONE=1 and irq_out=1.
- Clamp and zero: PERIOD=1 with STEPS=2 -> rises 4 cycles apart. STEPS=0 with START -> DONE=1, no pulse, busy never high.
- Abort: start ch1 with STEPS=100, assert ABORT after the 5th rise.
  - Required: step_out[1]=0 next cycle, ABORTED=1, DONE=0, STEPS reads 95 (or 96 if mid-high).
  - A restart clears ABORTED.
- Ignored writes while busy: write STEPS=50 and CTRL DIR=0 during a run -> pulse count and dir_out unchanged. A PERIOD change applies from the next rise.
- Reset: deassert reset_n_in during HIGH -> all outputs 0 asynchronously, registers read 0 after release.
